// File: rtl/mono_hub75_direct.sv
// mono_hub75_direct: RAM-less monochrome DMD row to HUB75 1/16-scan panel driver
module mono_hub75_direct #(
    parameter int CLK_DIV = 4,
    parameter int PIXELS  = 128,
    parameter int LINELEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIXELS-1:0] rowdata,
    input  logic [4:0]        address,
    input  logic              enable,
    output logic              hub75_r0,
    output logic              hub75_g0,
    output logic              hub75_b0,
    output logic              hub75_r1,
    output logic              hub75_g1,
    output logic              hub75_b1,
    output logic              hub75_a,
    output logic              hub75_b,
    output logic              hub75_c,
    output logic              hub75_d,
    output logic              hub75_lat,
    output logic              hub75_oe,
    output logic              hub75_clk
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(LINELEN);
    localparam int XW = $clog2(PIXELS);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(LINELEN - 1);
    localparam logic [SW-1:0] LAT_SLOT = SW'(LINELEN - 2);
    localparam logic [SW-1:0] PIX_END  = SW'(PIXELS);
    localparam logic [SW-1:0] OE_LO    = SW'(PIXELS + 1);
    localparam logic [SW-1:0] OE_HI    = SW'(LINELEN - 3);

    logic [PW-1:0]     pre_q, pre_d;
    logic              phase_q, phase_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [2:0]        sync_q, sync_d;
    logic [PIXELS-1:0] cap_data_q, cap_data_d, work_data_q, work_data_d;
    logic [4:0]        cap_addr_q, cap_addr_d, work_addr_q, work_addr_d;
    logic              up_q, up_d, lo_q, lo_d, sclk_q, sclk_d, lat_q, lat_d, oe_q, oe_d;
    logic [3:0]        row_q, row_d;
    logic              tick, slot_step, line_start, rise, shifting, pix_bit;

    // Outputs are registered from next-state values so they line up with the slot/phase they describe
    always_comb begin
        tick        = pre_q == PRE_MAX;
        pre_d       = tick ? '0 : pre_q + 1'b1;
        phase_d     = phase_q ^ tick;
        slot_step   = tick & phase_q;
        line_start  = slot_step & (slot_q == SLOT_MAX);
        slot_d      = !slot_step ? slot_q : (line_start ? '0 : slot_q + 1'b1);
        sync_d      = {sync_q[1:0], enable};
        rise        = sync_q[1] & ~sync_q[2];
        cap_data_d  = rise ? rowdata : cap_data_q;
        cap_addr_d  = rise ? address : cap_addr_q;
        work_data_d = line_start ? cap_data_q : work_data_q;
        work_addr_d = line_start ? cap_addr_q : work_addr_q;
        shifting    = slot_d < PIX_END;
        pix_bit     = shifting & work_data_d[slot_d[XW-1:0]];
        up_d        = pix_bit & ~work_addr_d[4];
        lo_d        = pix_bit & work_addr_d[4];
        sclk_d      = shifting & phase_d;
        lat_d       = slot_d == LAT_SLOT;
        oe_d        = !(slot_d >= OE_LO && slot_d <= OE_HI);
        row_d       = lat_d ? work_addr_d[3:0] : row_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            phase_q     <= 1'b0;
            slot_q      <= '0;
            sync_q      <= '0;
            cap_data_q  <= '0;
            cap_addr_q  <= '0;
            work_data_q <= '0;
            work_addr_q <= '0;
            up_q        <= 1'b0;
            lo_q        <= 1'b0;
            sclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_q        <= 1'b1;
            row_q       <= '0;
        end else begin
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            sync_q      <= sync_d;
            cap_data_q  <= cap_data_d;
            cap_addr_q  <= cap_addr_d;
            work_data_q <= work_data_d;
            work_addr_q <= work_addr_d;
            up_q        <= up_d;
            lo_q        <= lo_d;
            sclk_q      <= sclk_d;
            lat_q       <= lat_d;
            oe_q        <= oe_d;
            row_q       <= row_d;
        end
    end

    assign hub75_r0  = up_q;
    assign hub75_g0  = up_q;
    assign hub75_b0  = up_q;
    assign hub75_r1  = lo_q;
    assign hub75_g1  = lo_q;
    assign hub75_b1  = lo_q;
    assign hub75_a   = row_q[0];
    assign hub75_b   = row_q[1];
    assign hub75_c   = row_q[2];
    assign hub75_d   = row_q[3];
    assign hub75_lat = lat_q;
    assign hub75_oe  = oe_q;
    assign hub75_clk = sclk_q;
endmodule

// File: tb/tb_mono_hub75_direct.sv
// tb_mono_hub75_direct: directed line-level checks of the HUB75 driver
module tb_mono_hub75_direct;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] rowdata = '0;
    logic [4:0]   address = '0;
    logic         enable = 1'b0;
    logic         hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1;
    logic         hub75_a, hub75_b, hub75_c, hub75_d, hub75_lat, hub75_oe, hub75_clk;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [3:0]   cur_abcd = '0;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   addr;
        logic [127:0] e_up;
        logic [127:0] e_lo;
        logic [3:0]   e_abcd;
    } vec_t;
    vec_t vt[5];

    mono_hub75_direct dut (
        .clk(clk), .rst(rst), .rowdata(rowdata), .address(address), .enable(enable),
        .hub75_r0(hub75_r0), .hub75_g0(hub75_g0), .hub75_b0(hub75_b0),
        .hub75_r1(hub75_r1), .hub75_g1(hub75_g1), .hub75_b1(hub75_b1),
        .hub75_a(hub75_a), .hub75_b(hub75_b), .hub75_c(hub75_c), .hub75_d(hub75_d),
        .hub75_lat(hub75_lat), .hub75_oe(hub75_oe), .hub75_clk(hub75_clk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_line();
        int guard = 0;
        @(negedge clk);
        while (cyc % 2048 != 0 && guard < 4096) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4096) begin
            n_cmp++;
            n_bad++;
            $display("FAIL line_sync: got no line start expected one within 4096 cycles");
        end
    endtask

    function automatic logic [3:0] abcd();
        return {hub75_d, hub75_c, hub75_b, hub75_a};
    endfunction

    // Watches one whole line (2048 clk) and checks pixels, timing and row select
    task automatic observe(input logic [127:0] e_up, input logic [127:0] e_lo, input logic [3:0] e_abcd,
                           input bit mid, input logic [127:0] m_data, input logic [4:0] m_addr);
        logic [127:0] up = '0, lo = '0;
        logic pc = 1'b0;
        int k = 0, lat_n = 0, lat_slot = -1, oe_n = 0, oe_first = -1, viol = 0, gb = 0, stray = 0;
        logic [3:0] pre_abcd = '0;
        wait_line();
        for (int j = 0; j < 2048; j++) begin
            if (j > 0) @(negedge clk);
            if (mid && j == 500) begin
                rowdata = m_data;
                address = m_addr;
                enable = 1'b1;
            end
            if (mid && j == 508) enable = 1'b0;
            if (hub75_clk && !pc) begin
                if (k < 128) begin
                    up[k] = hub75_r0;
                    lo[k] = hub75_r1;
                end
                k++;
            end
            pc = hub75_clk;
            if (hub75_g0 !== hub75_r0 || hub75_b0 !== hub75_r0 || hub75_g1 !== hub75_r1 || hub75_b1 !== hub75_r1) gb++;
            if (hub75_lat) begin
                if (lat_slot < 0) lat_slot = j / 8;
                lat_n++;
            end
            if (!hub75_oe) begin
                if (oe_first < 0) oe_first = j;
                oe_n++;
                if (hub75_lat || hub75_clk) viol++;
            end
            if (j >= 1024 && (hub75_clk || hub75_r0 || hub75_g0 || hub75_b0 || hub75_r1 || hub75_g1 || hub75_b1)) stray++;
            if (j == 2031) pre_abcd = abcd();
        end
        chk("clk_pulses", k, 128);
        chk("upper_pixels", up, e_up);
        chk("lower_pixels", lo, e_lo);
        chk("rgb_equal", gb, 0);
        chk("lat_cycles", lat_n, 8);
        chk("lat_slot", lat_slot, 254);
        chk("oe_low_cycles", oe_n, 1000);
        chk("oe_first_low", oe_first, 1032);
        chk("oe_overlap", viol, 0);
        chk("idle_outputs", stray, 0);
        chk("abcd_held", pre_abcd, cur_abcd);
        chk("abcd_after_lat", abcd(), e_abcd);
        cur_abcd = e_abcd;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oe"}, hub75_oe, 1'b1);
        chk({tag, "_lat"}, hub75_lat, 1'b0);
        chk({tag, "_clk"}, hub75_clk, 1'b0);
        chk({tag, "_data"}, {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1}, 6'b0);
        chk({tag, "_abcd"}, abcd(), 4'b0);
    endtask

    initial begin
        vt[0] = '{128'h5, 5'd7, 128'h5, 128'h0, 4'b0111};
        vt[1] = '{{128{1'b1}}, 5'd20, 128'h0, {128{1'b1}}, 4'b0100};
        vt[2] = '{{1'b1, 126'h0, 1'b1}, 5'd15, {1'b1, 126'h0, 1'b1}, 128'h0, 4'b1111};
        vt[3] = '{{32{4'hA}}, 5'd16, 128'h0, {32{4'hA}}, 4'b0000};
        vt[4] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 5'd0, 128'h0123456789ABCDEF_FEDCBA9876543210, 128'h0, 4'b0000};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            wait_line();
            rowdata = vt[i].data;
            address = vt[i].addr;
            enable = 1'b1;
            repeat (6) @(negedge clk);
            enable = 1'b0;
            observe(vt[i].e_up, vt[i].e_lo, vt[i].e_abcd, 1'b0, '0, '0);
        end

        observe(vt[4].e_up, vt[4].e_lo, vt[4].e_abcd, 1'b1, 128'h3, 5'd18);
        observe(128'h0, 128'h3, 4'b0010, 1'b0, '0, '0);

        wait_line();
        rowdata = 128'hF0;
        address = 5'd9;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        rowdata = 128'hFF00;
        address = 5'd25;
        observe(128'hF0, 128'h0, 4'b1001, 1'b0, '0, '0);
        observe(128'hF0, 128'h0, 4'b1001, 1'b0, '0, '0);
        enable = 1'b0;

        wait_line();
        repeat (480) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        cur_abcd = 4'b0;
        repeat (4) @(negedge clk);
        chk("restart_slot0_clk", hub75_clk, 1'b1);
        chk("restart_slot0_data", {hub75_r0, hub75_r1}, 2'b0);
        observe(128'h0, 128'h0, 4'b0000, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
